// File: rtl/sar_pkg.sv
// Shared definitions for the behavioural SAR conversion stage.
//   sar_state_e     : conversion FSM states
//   SarNbitsDefault : default conversion resolution
//   sar_vdac()      : differential CDAC voltage for a given trial code
package sar_pkg;

  localparam int unsigned SarNbitsDefault = 8;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    COMPARE,
    DECIDE,
    DONE
  } sar_state_e;

  // Differential DAC voltage of an offset-binary trial code:
  // (vrefp - vrefn) * (2*trial - 2^nbits) / 2^nbits
  function automatic real sar_vdac(input int unsigned trial, input real vrefp,
                                   input real vrefn, input int unsigned nbits);
    real full;
    full = real'(longint'(1) << nbits);
    return (vrefp - vrefn) * (2.0 * real'(trial) - full) / full;
  endfunction

endpackage

// File: rtl/sar_cdac_model.sv
// Combinational real-valued CDAC top-plate model.
// Ports:
//   i_vs_p, i_vs_n   : held input samples, V
//   i_trial          : current trial code (offset binary)
//   i_vcm            : common-mode voltage, V
//   i_vrefp, i_vrefn : references, V
//   i_active         : high while a bit is being resolved
//   o_dac_p, o_dac_n : top-plate voltages seen by the comparator, V
module sar_cdac_model
  import sar_pkg::*;
#(
  parameter int unsigned NBITS = SarNbitsDefault
) (
  input  real              i_vs_p,
  input  real              i_vs_n,
  input  logic [NBITS-1:0] i_trial,
  input  real              i_vcm,
  input  real              i_vrefp,
  input  real              i_vrefn,
  input  logic             i_active,
  output real              o_dac_p,
  output real              o_dac_n
);

  real w_vdac;
  real w_half;

  assign w_vdac = sar_vdac(32'(i_trial), i_vrefp, i_vrefn, NBITS);

  // Residue split symmetrically around vcm; when idle both plates rest at vcm.
  assign w_half  = i_active ? ((i_vs_p - i_vs_n) - w_vdac) / 2.0 : 0.0;
  assign o_dac_p = i_vcm + w_half;
  assign o_dac_n = i_vcm - w_half;

endmodule

// File: rtl/sar_cdac_ctrl.sv
// SAR conversion controller: samples a differential real input, runs an
// NBITS binary search against an external comparator and publishes the code.
// Ports:
//   i_clk, i_rst_n    : clock, synchronous active-low reset
//   i_start           : conversion request
//   i_vip, i_vin      : differential analog input, V
//   i_vcm, i_vrefp/n  : common mode and references from the reference stage, V
//   i_comp_out        : comparator decision (1: dac_p >= dac_n)
//   o_comp_en         : comparator strobe, one cycle per bit
//   o_dac_p, o_dac_n  : CDAC top-plate voltages, V
//   o_busy            : conversion in progress (SAMPLE..DONE)
//   o_code, o_valid   : last result and its one-cycle update pulse
module sar_cdac_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned NBITS = SarNbitsDefault
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  real              i_vip,
  input  real              i_vin,
  input  real              i_vcm,
  input  real              i_vrefp,
  input  real              i_vrefn,
  input  logic             i_comp_out,
  output logic             o_comp_en,
  output real              o_dac_p,
  output real              o_dac_n,
  output logic             o_busy,
  output logic [NBITS-1:0] o_code,
  output logic             o_valid
);

  localparam int unsigned IdxW = (NBITS > 1) ? $clog2(NBITS) : 1;

  sar_state_e       r_state;
  logic [NBITS-1:0] r_trial;
  logic [IdxW-1:0]  r_idx;
  real              r_vs_p;
  real              r_vs_n;
  logic             r_comp_en;
  logic             r_busy;
  logic             r_valid;
  logic [NBITS-1:0] r_code;

  logic             w_active;
  logic [NBITS-1:0] w_trial_dec;

  assign w_active = (r_state == COMPARE) || (r_state == DECIDE);

  // Trial after the decision: drop the bit under test on a "low" verdict,
  // then arm the next lower bit if one remains.
  always_comb begin
    w_trial_dec = r_trial;
    if (!i_comp_out) begin
      w_trial_dec[r_idx] = 1'b0;
    end
    if (r_idx != '0) begin
      w_trial_dec[r_idx - IdxW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_trial   <= '0;
      r_idx     <= '0;
      r_vs_p    <= 0.0;
      r_vs_n    <= 0.0;
      r_comp_en <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_code    <= '0;
    end else begin
      r_comp_en <= 1'b0;
      r_valid   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= SAMPLE;
            r_busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          r_vs_p    <= i_vip;
          r_vs_n    <= i_vin;
          r_trial   <= {1'b1, {(NBITS-1){1'b0}}};
          r_idx     <= IdxW'(NBITS - 1);
          r_state   <= COMPARE;
          r_comp_en <= 1'b1;
        end
        COMPARE: begin
          r_state <= DECIDE;
        end
        DECIDE: begin
          r_trial <= w_trial_dec;
          if (r_idx != '0) begin
            r_idx     <= r_idx - IdxW'(1);
            r_state   <= COMPARE;
            r_comp_en <= 1'b1;
          end else begin
            r_code  <= w_trial_dec;
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          // busy stays high straight into the next SAMPLE for back-to-back runs
          if (i_start) begin
            r_state <= SAMPLE;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sar_cdac_model #(
    .NBITS(NBITS)
  ) u_cdac (
    .i_vs_p  (r_vs_p),
    .i_vs_n  (r_vs_n),
    .i_trial (r_trial),
    .i_vcm   (i_vcm),
    .i_vrefp (i_vrefp),
    .i_vrefn (i_vrefn),
    .i_active(w_active),
    .o_dac_p (o_dac_p),
    .o_dac_n (o_dac_n)
  );

  assign o_comp_en = r_comp_en;
  assign o_busy    = r_busy;
  assign o_valid   = r_valid;
  assign o_code    = r_code;

endmodule

// File: tb/tb_sar_cdac_ctrl.sv
// Directed self-checking bench for sar_cdac_ctrl with an ideal comparator.
module tb_sar_cdac_ctrl;

  localparam int unsigned NBITS = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             comp_out;
  real              vip;
  real              vin;
  real              vcm;
  real              vrefp;
  real              vrefn;
  logic             comp_en;
  real              dac_p;
  real              dac_n;
  logic             busy;
  logic [NBITS-1:0] code;
  logic             valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Ideal comparator, latched on the strobe cycle.
  always @(posedge clk) begin
    if (comp_en) comp_out <= (dac_p >= dac_n);
  end

  sar_cdac_ctrl #(
    .NBITS(NBITS)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_vip     (vip),
    .i_vin     (vin),
    .i_vcm     (vcm),
    .i_vrefp   (vrefp),
    .i_vrefn   (vrefn),
    .i_comp_out(comp_out),
    .o_comp_en (comp_en),
    .o_dac_p   (dac_p),
    .o_dac_n   (dac_n),
    .o_busy    (busy),
    .o_code    (code),
    .o_valid   (valid)
  );

  task automatic check_eq(input string tag, input real got, input real exp);
    n_checks++;
    if (got > exp + 1e-9 || got < exp - 1e-9) begin
      n_fail++;
      $display("FAIL %s: got %g, expected %g", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated conversion; n counts cycles with the SAMPLE cycle as 1.
  task automatic run_conv(input string tag, input real vp, input real vn, input int exp_code,
                          input bit chk_dac, input real exp_p, input real exp_n);
    int  n;
    int  ncmp;
    int  last;
    int  bad_gap;
    real fp;
    real fn;
    vip = vp;
    vin = vn;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1; ncmp = 0; last = 0; bad_gap = 0; fp = 0.0; fn = 0.0;
    while (!valid && n < 40) begin
      if (comp_en) begin
        if (ncmp == 0) begin
          fp = dac_p;
          fn = dac_n;
          if (n != 2) bad_gap++;
        end else if (n - last != 2) begin
          bad_gap++;
        end
        ncmp++;
        last = n;
      end
      step();
      n++;
    end
    check_eq({tag, "_latency"}, real'(n), 18.0);
    check_eq({tag, "_code"}, real'(code), real'(exp_code));
    check_eq({tag, "_strobes"}, real'(ncmp), 8.0);
    check_eq({tag, "_strobe_gap"}, real'(bad_gap), 0.0);
    if (chk_dac) begin
      check_eq({tag, "_dac_p_first"}, fp, exp_p);
      check_eq({tag, "_dac_n_first"}, fn, exp_n);
    end
    step();
    check_eq({tag, "_valid_pulse"}, real'(valid), 0.0);
    check_eq({tag, "_busy_after"}, real'(busy), 0.0);
  endtask

  initial begin
    int   n;
    int   ncmp;
    int   nval;
    int   vcyc;
    logic prev_valid;
    logic busy_after;

    rst_n = 1'b0; start = 1'b0; comp_out = 1'b0;
    vip = 0.5; vin = 0.5; vcm = 0.5; vrefp = 0.6; vrefn = 0.4;
    step();
    step();
    check_eq("rst_busy", real'(busy), 0.0);
    check_eq("rst_valid", real'(valid), 0.0);
    check_eq("rst_code", real'(code), 0.0);
    check_eq("rst_comp_en", real'(comp_en), 0.0);
    check_eq("rst_dac_p", dac_p, 0.5);
    check_eq("rst_dac_n", dac_n, 0.5);
    rst_n = 1'b1;
    step();

    run_conv("mid", 0.5, 0.5, 128, 1'b1, 0.5, 0.5);
    run_conv("pos_fs", 0.6, 0.4, 255, 1'b0, 0.0, 0.0);
    run_conv("neg_fs", 0.4, 0.6, 0, 1'b0, 0.0, 0.0);
    run_conv("sat", 0.7, 0.3, 255, 1'b0, 0.0, 0.0);
    run_conv("quarter", 0.52505, 0.47495, 160, 1'b1, 0.52505, 0.47495);

    // Back-to-back with start held; input moves mid-conversion (hold mode).
    vip = 0.5; vin = 0.5; start = 1'b1;
    step();
    n = 1;
    while (!valid && n < 40) begin
      if (n == 5) begin
        vip = 0.6;
        vin = 0.4;
      end
      step();
      n++;
    end
    check_eq("b2b_first_latency", real'(n), 18.0);
    check_eq("b2b_first_code", real'(code), 128.0);
    step();
    start = 1'b0;
    check_eq("b2b_busy_held", real'(busy), 1.0);
    n = 1;
    while (!valid && n < 40) begin
      step();
      n++;
    end
    check_eq("b2b_period", real'(n), 18.0);
    check_eq("b2b_second_code", real'(code), 255.0);
    step();
    check_eq("b2b_busy_end", real'(busy), 0.0);

    // Reset during the 5th DECIDE aborts the conversion.
    vip = 0.52505; vin = 0.47495; start = 1'b1;
    step();
    start = 1'b0;
    n = 1; ncmp = 0;
    while (n < 11) begin
      if (comp_en) ncmp++;
      step();
      n++;
    end
    check_eq("abort_strobes_before", real'(ncmp), 5.0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("abort_busy", real'(busy), 0.0);
    check_eq("abort_valid", real'(valid), 0.0);
    check_eq("abort_code", real'(code), 0.0);
    check_eq("abort_comp_en", real'(comp_en), 0.0);
    check_eq("abort_dac_p", dac_p, 0.5);
    check_eq("abort_dac_n", dac_n, 0.5);
    run_conv("fresh", 0.52505, 0.47495, 160, 1'b1, 0.52505, 0.47495);

    // start pulsed during the first COMPARE must be ignored.
    vip = 0.5; vin = 0.5; start = 1'b1;
    step();
    start = 1'b0;
    nval = 0; vcyc = 0; prev_valid = 1'b0; busy_after = 1'b1;
    for (int k = 1; k < 45; k++) begin
      start = (k == 2);
      if (prev_valid) busy_after = busy;
      if (valid) begin
        nval++;
        vcyc = k;
      end
      prev_valid = valid;
      step();
    end
    start = 1'b0;
    check_eq("ignore_valid_count", real'(nval), 1.0);
    check_eq("ignore_valid_cycle", real'(vcyc), 18.0);
    check_eq("ignore_busy_drop", real'(busy_after), 0.0);
    check_eq("ignore_code", real'(code), 128.0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
